// File: rtl/ws_video_pkg.sv
// Shared WonderSwan video constants, window-offset helper and rotation mode.
// Imported by the frame-buffer read address generator and its sub-blocks.
package ws_video_pkg;

    localparam int SRC_W = 224;
    localparam int SRC_H = 144;

    // Offset that centres a window of size win inside an active area of size frame
    function automatic int center_off(input int frame, input int win);
        return (frame - win) / 2;
    endfunction

    // Default geometry for a 720x480 output
    localparam int LAND_HOFF = center_off(720, SRC_W * 3);
    localparam int LAND_VOFF = center_off(480, SRC_H * 3);
    localparam int ROT_HOFF  = center_off(720, SRC_H * 2);
    localparam int ROT_VOFF  = center_off(480, SRC_W * 2);

    typedef enum logic {
        ROT_LANDSCAPE = 1'b0,
        ROT_PORTRAIT  = 1'b1
    } rot_mode_t;

endpackage

// File: rtl/ws_scale_stepper.sv
// Modulo-scale sub-counter for one raster axis.
// Ports: clk, rst_n, clr/load (restart at 0), en (advance), scale, step (last slot of group).
module ws_scale_stepper #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    input  logic [SW-1:0] scale,
    output logic          step
);

    logic [SW-1:0] cnt;

    assign step = en && (cnt == scale - SW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= step ? '0 : cnt + SW'(1);
        end
    end

endmodule

// File: rtl/ws_fb_read_addr_gen.sv
// Frame-buffer read address generator for the HDMI path: raster tracking plus scaled window mapping.
// Ports: clk, rst_n, sync_in, rot -> rd_addr, rd_en, in_window, frame_start, line_start (1-cycle latency).
module ws_fb_read_addr_gen #(
    parameter int FRAMEWIDTH  = 720,
    parameter int FRAMEHEIGHT = 480,
    parameter int TOTALWIDTH  = 858,
    parameter int TOTALHEIGHT = 525,
    parameter int SCALE       = 3,
    parameter int SCALEROT    = 2,
    parameter int SRC_W       = ws_video_pkg::SRC_W,
    parameter int SRC_H       = ws_video_pkg::SRC_H,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_in,
    input  logic              rot,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              in_window,
    output logic              frame_start,
    output logic              line_start
);

    import ws_video_pkg::*;

    localparam int HW = $clog2(TOTALWIDTH);
    localparam int VW = $clog2(TOTALHEIGHT);

    localparam int L_WW   = SRC_W * SCALE;
    localparam int L_WH   = SRC_H * SCALE;
    localparam int R_WW   = SRC_H * SCALEROT;
    localparam int R_WH   = SRC_W * SCALEROT;
    localparam int L_HOFF = center_off(FRAMEWIDTH, L_WW);
    localparam int L_VOFF = center_off(FRAMEHEIGHT, L_WH);
    localparam int R_HOFF = center_off(FRAMEWIDTH, R_WW);
    localparam int R_VOFF = center_off(FRAMEHEIGHT, R_WH);

    logic [HW-1:0]     h, hoff, hend, hpre;
    logic [VW-1:0]     v, voff, vend;
    logic [3:0]        scale;
    rot_mode_t         rot_q;
    logic              portrait, h_last, v_last, in_h, in_v, win;
    logic              h_load, v_load, v_en, h_step, v_step;
    logic [ADDR_W-1:0] base, addr_run;

    assign portrait = (rot_q == ROT_PORTRAIT);

    always_comb begin
        hoff  = HW'(L_HOFF);
        hend  = HW'(L_HOFF + L_WW);
        voff  = VW'(L_VOFF);
        vend  = VW'(L_VOFF + L_WH);
        scale = 4'(SCALE);
        if (portrait) begin
            hoff  = HW'(R_HOFF);
            hend  = HW'(R_HOFF + R_WW);
            voff  = VW'(R_VOFF);
            vend  = VW'(R_VOFF + R_WH);
            scale = 4'(SCALEROT);
        end
    end

    assign hpre   = hoff - HW'(1);
    assign h_last = (h == HW'(TOTALWIDTH - 1));
    assign v_last = (v == VW'(TOTALHEIGHT - 1));
    assign in_h   = (h >= hoff) && (h < hend);
    assign in_v   = (v >= voff) && (v < vend);
    assign win    = in_h && in_v;

    // Line base is settled at h=0; the pixel run loads it just before the
    // window edge, so the window must start at h >= 2.
    assign v_load = (h == '0) && (v == voff);
    assign v_en   = (h == '0) && (v > voff) && (v < vend);
    assign h_load = (h == hpre);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (sync_in) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= ROT_LANDSCAPE;
        end else if ((h == '0) && (v == '0)) begin
            rot_q <= rot_mode_t'(rot);
        end
    end

    ws_scale_stepper #(.SW(4)) u_h_step (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_in),
        .load  (h_load),
        .en    (win),
        .scale (scale),
        .step  (h_step)
    );

    ws_scale_stepper #(.SW(4)) u_v_step (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_in),
        .load  (v_load),
        .en    (v_en),
        .scale (scale),
        .step  (v_step)
    );

    // Portrait walks source columns: base moves by -1 per row group,
    // pixels advance a whole source line per column group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            addr_run <= '0;
        end else if (sync_in) begin
            base     <= '0;
            addr_run <= '0;
        end else begin
            if (v_load) begin
                base <= portrait ? ADDR_W'(SRC_W - 1) : '0;
            end else if (v_en && v_step) begin
                base <= portrait ? base - ADDR_W'(1) : base + ADDR_W'(SRC_W);
            end
            if (h_load) begin
                addr_run <= base;
            end else if (win && h_step) begin
                addr_run <= portrait ? addr_run + ADDR_W'(SRC_W)
                                     : addr_run + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            rd_en       <= win && !sync_in;
            frame_start <= (h == '0) && (v == '0);
            line_start  <= (h == '0);
            if (win && !sync_in) begin
                rd_addr <= addr_run;
            end
        end
    end

    assign in_window = rd_en;

endmodule

// File: tb/tb_ws_fb_read_addr_gen.sv
// Directed bench for ws_fb_read_addr_gen on a reduced raster (50x36 total, 8x6 source).
// Landscape window 24x18 at (8,6); portrait window 12x16 at (14,7).
module tb_ws_fb_read_addr_gen;

    localparam int TW = 50;
    localparam int TH = 36;
    localparam int FRAME = TW * TH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_in = 1'b0;
    logic        rot = 1'b0;
    logic [14:0] rd_addr;
    logic        rd_en, in_window, frame_start, line_start;

    int checks = 0;
    int failures = 0;
    int th = 0;
    int tv = 0;

    always #5 clk = ~clk;

    ws_fb_read_addr_gen #(
        .FRAMEWIDTH  (40),
        .FRAMEHEIGHT (30),
        .TOTALWIDTH  (TW),
        .TOTALHEIGHT (TH),
        .SCALE       (3),
        .SCALEROT    (2),
        .SRC_W       (8),
        .SRC_H       (6),
        .ADDR_W      (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_in     (sync_in),
        .rot         (rot),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .in_window   (in_window),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    // Expected raster position, tracked from the stimulus the bench drives
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th <= 0;
            tv <= 0;
        end else if (sync_in) begin
            th <= 0;
            tv <= 0;
        end else if (th == TW - 1) begin
            th <= 0;
            tv <= (tv == TH - 1) ? 0 : tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (!(th == h && tv == v)) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                checks++;
                failures++;
                $error("FAIL timeout waiting for (%0d,%0d)", h, v);
                return;
            end
        end
    endtask

    task automatic at_pos(input int h, input int v, input logic en, input int addr, input string tag);
        wait_pos(h, v);
        @(posedge clk);
        #1;
        chk({tag, "_en"}, 32'(rd_en), 32'(en));
        chk({tag, "_win"}, 32'(in_window), 32'(en));
        chk({tag, "_addr"}, 32'(rd_addr), 32'(addr));
    endtask

    initial begin
        int n, fs, ens, last;

        #1;
        chk("rst_en", 32'(rd_en), 0);
        chk("rst_addr", 32'(rd_addr), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_ls", 32'(line_start), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_fs", 32'(frame_start), 1);
        chk("first_ls", 32'(line_start), 1);

        // Landscape frame
        at_pos(7, 6, 1'b0, 0, "l_left");
        at_pos(8, 6, 1'b1, 0, "l_origin");
        at_pos(11, 6, 1'b1, 1, "l_h11");
        at_pos(31, 6, 1'b1, 7, "l_hend");
        at_pos(32, 6, 1'b0, 7, "l_hout");
        at_pos(8, 9, 1'b1, 8, "l_row1");
        rot = 1'b1;
        at_pos(8, 15, 1'b1, 24, "l_midrot");
        at_pos(31, 23, 1'b1, 47, "l_last");
        at_pos(32, 23, 1'b0, 47, "l_lastout");

        // Portrait frame
        at_pos(13, 7, 1'b0, 47, "r_left");
        at_pos(14, 7, 1'b1, 7, "r_origin");
        at_pos(16, 7, 1'b1, 15, "r_col1");
        at_pos(14, 9, 1'b1, 6, "r_row1");
        at_pos(25, 22, 1'b1, 40, "r_last");
        at_pos(26, 22, 1'b0, 40, "r_lastout");
        rot = 1'b0;

        // Mid-frame sync restart
        at_pos(8, 6, 1'b1, 0, "s_pre");
        wait_pos(20, 15);
        sync_in = 1'b1;
        @(posedge clk);
        #1;
        sync_in = 1'b0;
        @(posedge clk);
        #1;
        chk("sync_fs", 32'(frame_start), 1);
        chk("sync_ls", 32'(line_start), 1);
        at_pos(8, 6, 1'b1, 0, "s_origin");
        at_pos(11, 7, 1'b1, 1, "s_h11");

        // Asynchronous reset mid-frame
        wait_pos(20, 18);
        rst_n = 1'b0;
        #1;
        chk("ar_en", 32'(rd_en), 0);
        chk("ar_addr", 32'(rd_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_fs", 32'(frame_start), 1);
        chk("ar_en_after", 32'(rd_en), 0);
        at_pos(7, 6, 1'b0, 0, "ar_left");
        at_pos(8, 6, 1'b1, 0, "ar_origin");

        // Three free-running frames
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_start && n < 4000);
        chk("fs_found", 32'(frame_start), 1);
        fs = 0;
        ens = 0;
        last = 0;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (rd_en) ens++;
            if (frame_start) begin
                fs++;
                chk("fs_period", 32'(i - last), 32'(FRAME));
                last = i;
            end
        end
        chk("fs_count", 32'(fs), 3);
        chk("en_count", 32'(ens), 3 * 24 * 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws_fb_read_addr_gen.md
Name: ws_fb_read_addr_gen

Overview:
- Generates frame-buffer read addresses for the HDMI output path.
- Tracks raster position over the full TOTALWIDTH x TOTALHEIGHT output frame, locked to the HDMI core by a sync pulse.
- Maps each output pixel inside the centred, integer-scaled WonderSwan window (224x144 source) to a linear source address. Landscape mode uses SCALE; rotated (vertical-game) mode uses SCALEROT with a 90-degree remap.
- Sits directly upstream of the frame-buffer BRAM read port, which feeds the HDMI encoder. Multiplier-free: incremental address stepping only.

Parameters:
- FRAMEWIDTH, 720, active output width in pixels
- FRAMEHEIGHT, 480, active output height in lines
- TOTALWIDTH, 858, total pixels per line including blanking
- TOTALHEIGHT, 525, total lines per frame including blanking
- SCALE, 3, integer upscale factor in landscape mode
- SCALEROT, 2, integer upscale factor in rotated mode
- SRC_W, 224, source width in pixels
- SRC_H, 144, source height in pixels
- ADDR_W, 15, read address width; SRC_W*SRC_H-1 = 32255 must fit

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- sync_in  in  1  one-cycle pulse; on the following cycle the raster counters are at (0,0)
- rot  in  1  rotated-mode request; sampled only at frame start
- rd_addr  out  ADDR_W  frame-buffer read address
- rd_en  out  1  read strobe; high only when the pixel is inside the window
- in_window  out  1  pixel is inside the scaled window; equal to rd_en
- frame_start  out  1  one-cycle pulse when the raster is at (0,0)
- line_start  out  1  one-cycle pulse when h = 0

Behaviour:
- Reset: h=0, v=0, rot_q=0; all outputs 0; all address and step state 0.
- Raster counters:
  - h counts 0..TOTALWIDTH-1, then wraps to 0 and increments v.
  - v counts 0..TOTALHEIGHT-1, then wraps to 0.
- sync_in:
  - Forces h=0, v=0 on the next cycle and clears all address state.
  - Valid at any time, including mid-frame (full restart) and coincident with natural wrap (identical result).
- rot_q latches rot only when h=0 and v=0. A rot change mid-frame has no effect until the next frame.
- Window geometry, with WW = SRC_W*S, WH = SRC_H*S for landscape and WW = SRC_H*S, WH = SRC_W*S for rotated:
  - Offsets: HOFF = (FRAMEWIDTH-WW)/2, VOFF = (FRAMEHEIGHT-WH)/2.
  - Landscape defaults: HOFF=24, VOFF=24, window 672x432.
  - Rotated defaults: HOFF=216, VOFF=16, window 288x448.
- Landscape stepping:
  - Line base starts at 0 at v=VOFF and advances by SRC_W every SCALE window lines.
  - Within a line, the address starts at the base at h=HOFF and increments by 1 every SCALE pixels.
- Rotated stepping:
  - Line base starts at SRC_W-1 at v=VOFF and decrements by 1 every SCALEROT lines.
  - Within a line, the address starts at the base and increments by SRC_W every SCALEROT pixels.
  - This gives src_x = SRC_W-1-row', src_y = col'.
- Per-axis sub-counters count 0..S-1 and are reset at the window start of their axis.
- Latency: outputs are registered, so rd_addr/rd_en for raster position (h,v) appear one cycle after the counters hold (h,v). BRAM data follows one cycle later, two cycles in total.
- Outside the window: rd_en=0 and rd_addr holds its last value.
- frame_start and line_start are aligned with the same one-cycle latency.
- Reset asserted mid-frame: all state clears immediately (asynchronous). Counting resumes at (0,0) after release, without waiting for sync_in.

Decomposition:
- Package ws_video_pkg holds:
  - SRC_W, SRC_H
  - Derived HOFF/VOFF localparams for both modes
  - A rot_mode_t enum {ROT_LANDSCAPE, ROT_PORTRAIT}
- Sub-module ws_scale_stepper: a modulo-S sub-counter with load and step-pulse output. It is instantiated once per axis; S is selected from SCALE or SCALEROT by rot_q.

Test Plan:
- Landscape, free-running after reset:
  - Counters (24,24) -> rd_addr=0, rd_en=1 one cycle later.
  - h=27 -> 1; h=695 -> 223; h=696 -> rd_en=0.
  - v=27, h=24 -> 224; v=455, h=695 -> 32255.
- Rotated (rot=1 before frame start):
  - (216,16) -> 223; h=218 -> 447.
  - v=18, h=216 -> 222; (503,463) -> 32032; h=504 -> rd_en=0.
- Toggle rot at v=100: addresses keep the landscape pattern for the rest of the frame. The next frame starts at (216,16) with 223.
- sync_in pulse at (400,200): next cycle counters are (0,0), frame_start=1. The window is re-entered at (24,24) with rd_addr=0.
- Assert rst_n=0 at (300,300) for 3 cycles: outputs go 0 immediately. After release, h counts from 0 and rd_en stays 0 until (24,24).
- Run 3 full frames without sync_in: frame_start fires every 858*525 = 450450 cycles, with exactly 672*432 rd_en cycles per frame in landscape.
